// File: rtl/az_result_collector.sv
// Auto-zero result collector: pairs HI/LO adc samples, queues signed HI-LO in a show-ahead FIFO.
// Optional AZ_COLLECT_RAW_EN stores raw hi/lo with each difference and exposes rd_hi/rd_lo.
module az_result_collector #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             meas_done,
  input  logic             meas_is_hi,
  input  logic [WIDTH-1:0] meas_count,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH:0]   rd_data,
  output logic [CW-1:0]    fifo_count,
  output logic             overflow,
  output logic             seq_error,
  input  logic             clear_flags,
`ifdef AZ_COLLECT_RAW_EN
  output logic [WIDTH-1:0] rd_hi,
  output logic [WIDTH-1:0] rd_lo,
`endif
  output logic [1:0]       monitor
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = WIDTH + 1;
`ifdef AZ_COLLECT_RAW_EN
  localparam int unsigned EW = DW + 2 * WIDTH;
`else
  localparam int unsigned EW = DW;
`endif

  typedef enum logic [1:0] {WAIT_HI, WAIT_LO, PUSH} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hi_reg;
  logic [DW-1:0]    diff_reg;
  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    head_c;
  logic [EW-1:0]    entry_c;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_nxt_c;
  logic             hi_load_c, lo_load_c, seq_set_c;
  logic             push_c, pop_c, full_c, wr_c, ovf_set_c;
`ifdef AZ_COLLECT_RAW_EN
  logic [WIDTH-1:0] lo_reg;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_HI;
    else        state <= state_nxt;
  end

  // Pairing sequencer: any out-of-order or mid-push sample flags seq_error.
  always_comb begin
    state_nxt = state;
    hi_load_c = 1'b0;
    lo_load_c = 1'b0;
    seq_set_c = 1'b0;
    push_c    = 1'b0;
    case (state)
      WAIT_HI: begin
        if (meas_done) begin
          if (meas_is_hi) begin
            hi_load_c = 1'b1;
            state_nxt = WAIT_LO;
          end else begin
            seq_set_c = 1'b1;
          end
        end
      end
      WAIT_LO: begin
        if (meas_done) begin
          if (meas_is_hi) begin
            hi_load_c = 1'b1;
            seq_set_c = 1'b1;
          end else begin
            lo_load_c = 1'b1;
            state_nxt = PUSH;
          end
        end
      end
      PUSH: begin
        push_c    = 1'b1;
        seq_set_c = meas_done;
        state_nxt = WAIT_HI;
      end
      default: state_nxt = WAIT_HI;
    endcase
  end

  // FIFO control: a pop in the push cycle frees the slot even when full.
  always_comb begin
    full_c      = (fifo_count == CW'(DEPTH));
    pop_c       = rd_en & (fifo_count != '0);
    wr_c        = push_c & (~full_c | pop_c);
    ovf_set_c   = push_c & full_c & ~pop_c;
    count_nxt_c = fifo_count;
    if (wr_c && !pop_c)      count_nxt_c = fifo_count + CW'(1);
    else if (!wr_c && pop_c) count_nxt_c = fifo_count - CW'(1);
`ifdef AZ_COLLECT_RAW_EN
    entry_c = {hi_reg, lo_reg, diff_reg};
`else
    entry_c = diff_reg;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_reg     <= '0;
      diff_reg   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      seq_error  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
`ifdef AZ_COLLECT_RAW_EN
      lo_reg     <= '0;
`endif
    end else begin
      if (hi_load_c) hi_reg <= meas_count;
      if (lo_load_c) begin
        diff_reg <= {1'b0, hi_reg} - {1'b0, meas_count};
`ifdef AZ_COLLECT_RAW_EN
        lo_reg   <= meas_count;
`endif
      end
      if (wr_c) begin
        mem[wr_ptr] <= entry_c;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_nxt_c;
      // Set beats a simultaneous clear.
      overflow   <= ovf_set_c | (overflow & ~clear_flags);
      seq_error  <= seq_set_c | (seq_error & ~clear_flags);
    end
  end

  assign head_c   = mem[rd_ptr];
  assign rd_data  = head_c[DW-1:0];
  assign rd_valid = (fifo_count != '0);
  assign monitor  = {state == PUSH, state == WAIT_LO};
`ifdef AZ_COLLECT_RAW_EN
  assign rd_hi    = head_c[EW-1 -: WIDTH];
  assign rd_lo    = head_c[DW+WIDTH-1 -: WIDTH];
`endif

endmodule

// File: tb/tb_az_result_collector.sv
// Directed plus randomized bench for az_result_collector against a transaction-level queue model.
module tb_az_result_collector;
  localparam int unsigned WIDTH = 24;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             meas_done, meas_is_hi, rd_en, clear_flags;
  logic [WIDTH-1:0] meas_count;
  logic             rd_valid, overflow, seq_error;
  logic [WIDTH:0]   rd_data;
  logic [CW-1:0]    fifo_count;
  logic [1:0]       monitor;
`ifdef AZ_COLLECT_RAW_EN
  logic [WIDTH-1:0] rd_hi, rd_lo;
`endif

  az_result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .meas_done(meas_done), .meas_is_hi(meas_is_hi),
    .meas_count(meas_count), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_count(fifo_count), .overflow(overflow), .seq_error(seq_error),
    .clear_flags(clear_flags),
`ifdef AZ_COLLECT_RAW_EN
    .rd_hi(rd_hi), .rd_lo(rd_lo),
`endif
    .monitor(monitor)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending HI sample, queue of differences, sticky flags.
  logic [WIDTH:0]   q[$];
  logic             m_have_hi;
  logic [WIDTH-1:0] m_hi;
  logic             m_ovf, m_seq;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_have_hi = 1'b0;
    m_hi      = '0;
    m_ovf     = 1'b0;
    m_seq     = 1'b0;
  endtask

  function automatic logic [WIDTH:0] diff_of(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l);
    return {1'b0, h} - {1'b0, l};
  endfunction

  task automatic m_sample(input logic hi, input logic [WIDTH-1:0] cnt);
    if (hi) begin
      if (m_have_hi) m_seq = 1'b1;
      m_hi      = cnt;
      m_have_hi = 1'b1;
    end else if (!m_have_hi) begin
      m_seq = 1'b1;
    end else begin
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back(diff_of(m_hi, cnt));
      m_have_hi = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":count"}, 64'(fifo_count), 64'(q.size()));
    chk({tag, ":valid"}, 64'(rd_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk({tag, ":data"}, 64'(rd_data), 64'(q[0]));
    chk({tag, ":ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ":seq"}, 64'(seq_error), 64'(m_seq));
    chk({tag, ":mon"}, 64'(monitor), {62'd0, 1'b0, m_have_hi});
  endtask

  task automatic send(input logic hi, input logic [WIDTH-1:0] cnt);
    meas_done = 1'b1; meas_is_hi = hi; meas_count = cnt;
    step();
    meas_done = 1'b0; meas_is_hi = 1'b0; meas_count = '0;
    repeat (3) step();
    m_sample(hi, cnt);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clear();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    m_ovf = 1'b0;
    m_seq = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] c1, c2;
    int unsigned      r;
    reset = 1'b0; meas_done = 1'b0; meas_is_hi = 1'b0; meas_count = '0;
    rd_en = 1'b0; clear_flags = 1'b0;
    m_reset();
    repeat (2) step();
    reset = 1'b1;
    step();
    check_all("reset");
    chk("reset:rd_data", 64'(rd_data), 64'd0);

    // HI=1000, LO=1500 with edge-accurate latency
    send(1'b1, 24'd1000);
    chk("lat:mon_hi", 64'(monitor), 64'd1);
    meas_done = 1'b1; meas_is_hi = 1'b0; meas_count = 24'd1500;
    step();
    meas_done = 1'b0; meas_count = '0;
    chk("lat:valid_n", 64'(rd_valid), 64'd0);
    chk("lat:mon_push", 64'(monitor), 64'd2);
    step();
    chk("lat:valid_n1", 64'(rd_valid), 64'd1);
    chk("lat:data", 64'(rd_data), 64'(25'h1FFFE0C));
    chk("lat:mon_idle", 64'(monitor), 64'd0);
    m_have_hi = 1'b0;
    q.push_back(diff_of(24'd1000, 24'd1500));
    step();
    check_all("neg500");
    pop();
    check_all("neg500_pop");

    // Stray LO first
    send(1'b0, 24'd7);
    send(1'b1, 24'd10);
    send(1'b0, 24'd3);
    check_all("stray_lo");
    chk("stray_lo:val", 64'(rd_data), 64'd7);
    pop(); clear();
    check_all("stray_lo_clr");

    // Double HI: latest HI used
    send(1'b1, 24'd5);
    send(1'b1, 24'd9);
    send(1'b0, 24'd4);
    check_all("dbl_hi");
    chk("dbl_hi:val", 64'(rd_data), 64'd5);
    pop(); clear();

    // Overflow: DEPTH+1 pairs, diffs 1..5
    for (int i = 1; i <= 5; i++) begin
      send(1'b1, 24'(10 + i));
      send(1'b0, 24'd10);
    end
    check_all("ovf_fill");
    chk("ovf:flag", 64'(overflow), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf:order", 64'(rd_data), 64'(i));
      pop();
    end
    check_all("ovf_drained");
    clear();
    check_all("ovf_clr");

    // Full FIFO with pop in the push cycle
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 24'(20 + i));
      send(1'b0, 24'd0);
    end
    send(1'b1, 24'd300);
    meas_done = 1'b1; meas_is_hi = 1'b0; meas_count = 24'd1;
    step();
    meas_done = 1'b0; meas_count = '0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    void'(q.pop_front());
    q.push_back(diff_of(24'd300, 24'd1));
    m_have_hi = 1'b0;
    check_all("full_pushpop");
    chk("full_pushpop:head", 64'(rd_data), 64'd21);
    repeat (5) pop();
    check_all("empty_pop");
    pop();
    check_all("underflow");

    // Set wins over clear
    meas_done = 1'b1; meas_is_hi = 1'b0; meas_count = 24'd2; clear_flags = 1'b1;
    step();
    meas_done = 1'b0; clear_flags = 1'b0;
    m_ovf = 1'b0; m_seq = 1'b1;
    step();
    check_all("set_wins");

    // Async reset mid-WAIT_LO with 2 entries queued
    clear();
    send(1'b1, 24'd50); send(1'b0, 24'd1);
    send(1'b1, 24'd60); send(1'b0, 24'd2);
    send(1'b1, 24'd70);
    check_all("pre_reset");
    #2 reset = 1'b0;
    #1;
    m_reset();
    check_all("async_reset");
    step();
    reset = 1'b1;
    step();
    send(1'b1, 24'd100);
    send(1'b0, 24'd40);
    check_all("post_reset");
    chk("post_reset:val", 64'(rd_data), 64'd60);
    pop();

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      r  = $urandom_range(0, 99);
      c1 = WIDTH'($urandom());
      c2 = WIDTH'($urandom_range(0, 3));
      if (r < 40)      send(1'b1, (c2 == 0) ? c1 : WIDTH'(c2));
      else if (r < 80) send(1'b0, c1);
      else if (r < 93) pop();
      else             clear();
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
